// File: rtl/fnd_bcd_adder_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fnd_pkg                                                         |
// | Purpose  : Shared types, 7-segment font constants and the BCD digit        |
// |            validity helper for the fnd_bcd_adder_scan block.               |
// | Contents : bcd_digit_t, FONT_0..FONT_9, FONT_E, FONT_BLANK, bcd_valid()    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package fnd_pkg;

  typedef logic [3:0] bcd_digit_t;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a}; dp is always off.
  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_E     = 8'h86;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  function automatic logic bcd_valid(input bcd_digit_t d);
    return (d <= 4'd9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fnd_bcd_adder_scan_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fnd_bcd_adder_scan_if                                           |
// | Purpose  : Bus bundle between the operand source / FND pins and the        |
// |            BCD adder + display scanner.                                    |
// | Ports    : i_load, i_a, i_b, i_en          (master -> slave)               |
// |            o_sum_bcd, o_err, o_busy,                                       |
// |            o_digit, o_fndfont              (slave -> master)               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface fnd_bcd_adder_scan_if #(
  parameter int OPER_DIGITS = 3,
  parameter int DIGITS      = OPER_DIGITS + 1
);

  logic                     i_load;
  logic [4*OPER_DIGITS-1:0] i_a;
  logic [4*OPER_DIGITS-1:0] i_b;
  logic                     i_en;
  logic [4*DIGITS-1:0]      o_sum_bcd;
  logic                     o_err;
  logic                     o_busy;
  logic [DIGITS-1:0]        o_digit;
  logic [7:0]               o_fndfont;

  modport master (
    output i_load, i_a, i_b, i_en,
    input  o_sum_bcd, o_err, o_busy, o_digit, o_fndfont
  );

  modport slave (
    input  i_load, i_a, i_b, i_en,
    output o_sum_bcd, o_err, o_busy, o_digit, o_fndfont
  );

endinterface
`default_nettype wire

// File: rtl/fnd_bcd_adder_scan_font_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fnd_font_decoder                                                |
// | Purpose  : Combinational BCD digit to active-low 7-segment font.           |
// | Ports    : i_digit  in  4  BCD digit                                       |
// |            i_blank  in  1  force blank font                                |
// |            i_err    in  1  show 'E' (overrides blank)                      |
// |            o_font   out 8  {dp,g,f,e,d,c,b,a}, active low                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fnd_font_decoder
  import fnd_pkg::*;
(
  input  bcd_digit_t  i_digit,
  input  logic        i_blank,
  input  logic        i_err,
  output logic [7:0]  o_font
);

  always_comb begin
    o_font = FONT_BLANK;
    if (i_err) begin
      o_font = FONT_E;
    end else if (!i_blank) begin
      case (i_digit)
        4'd0:    o_font = FONT_0;
        4'd1:    o_font = FONT_1;
        4'd2:    o_font = FONT_2;
        4'd3:    o_font = FONT_3;
        4'd4:    o_font = FONT_4;
        4'd5:    o_font = FONT_5;
        4'd6:    o_font = FONT_6;
        4'd7:    o_font = FONT_7;
        4'd8:    o_font = FONT_8;
        4'd9:    o_font = FONT_9;
        default: o_font = FONT_BLANK;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fnd_bcd_adder_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fnd_bcd_adder_scan                                              |
// | Purpose  : Multi-digit BCD adder with time-multiplexed common-anode FND    |
// |            driver. Operands are captured on i_load, summed in one compute  |
// |            cycle, and the held sum is scanned one digit per SCAN_DIV clks. |
// | Ports    : i_clk, i_reset (sync, active high)                              |
// |            bus (slave): i_load, i_a, i_b, i_en, o_sum_bcd, o_err, o_busy,  |
// |                         o_digit, o_fndfont                                 |
// | Config   : FND_LEADING_ZERO_BLANK_EN - blank zero digits above the         |
// |            highest non-zero digit (digit 0 always shown).                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fnd_bcd_adder_scan
  import fnd_pkg::*;
#(
  parameter int OPER_DIGITS = 3,
  parameter int DIGITS      = OPER_DIGITS + 1,
  parameter int SCAN_DIV    = 100000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  fnd_bcd_adder_scan_if.slave  bus
);

  localparam int OPER_W = 4 * OPER_DIGITS;
  localparam int SUM_W  = 4 * DIGITS;
  localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  state_t              r_state;
  logic [OPER_W-1:0]   r_a;
  logic [OPER_W-1:0]   r_b;
  logic [SUM_W-1:0]    r_sum;
  logic                r_err;
  logic                r_busy;
  logic [CNT_W-1:0]    r_scan_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [DIGITS-1:0]   r_digit;
  logic [7:0]          r_font;

  logic [OPER_DIGITS:0]     w_carry;
  logic [OPER_W-1:0]        w_digits;
  logic [2*OPER_DIGITS-1:0] w_nib_ok;
  logic                     w_ops_valid;
  logic [SUM_W-1:0]         w_sum_full;

  // Decimal ripple adder over the captured operands; a digit sum above 9
  // is corrected by +6 and carries into the next digit.
  assign w_carry[0] = 1'b0;

  for (genvar g = 0; g < OPER_DIGITS; g++) begin : g_add
    logic [4:0] w_raw;
    assign w_nib_ok[2*g]     = bcd_valid(r_a[4*g +: 4]);
    assign w_nib_ok[2*g+1]   = bcd_valid(r_b[4*g +: 4]);
    assign w_raw             = {1'b0, r_a[4*g +: 4]} + {1'b0, r_b[4*g +: 4]}
                             + {4'b0000, w_carry[g]};
    assign w_carry[g+1]      = (w_raw > 5'd9);
    assign w_digits[4*g +: 4] = w_carry[g+1] ? 4'(w_raw + 5'd6) : w_raw[3:0];
  end

  assign w_ops_valid = &w_nib_ok;
  // The final carry lands in the extra top display digit.
  assign w_sum_full  = SUM_W'({w_carry[OPER_DIGITS], w_digits});

  // Load / compute FSM. i_load is only honoured in IDLE, so a held strobe
  // re-captures every other cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_load) begin
            r_a     <= bus.i_a;
            r_b     <= bus.i_b;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_busy  <= 1'b0;
          r_err   <= ~w_ops_valid;
          r_sum   <= w_ops_valid ? w_sum_full : '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Display source selection for the digit slot currently being scanned.
  bcd_digit_t w_sel_digit;
  logic       w_lz_blank;
  logic       w_dec_err;
  logic       w_dec_blank;
  logic [7:0] w_font;

  assign w_sel_digit = r_sum[{r_idx, 2'b00} +: 4];

`ifdef FND_LEADING_ZERO_BLANK_EN
  // Blank when this digit and everything above it are zero; slot 0 always shows.
  assign w_lz_blank = (r_idx != '0) && ((r_sum >> {r_idx, 2'b00}) == '0);
`else
  assign w_lz_blank = 1'b0;
`endif

  // On error only slot 0 carries the 'E'; every other slot is dark.
  assign w_dec_err   = r_err && (r_idx == '0);
  assign w_dec_blank = r_err || w_lz_blank;

  fnd_font_decoder u_font (
    .i_digit (w_sel_digit),
    .i_blank (w_dec_blank),
    .i_err   (w_dec_err),
    .o_font  (w_font)
  );

  // Scan counter keeps running while the display is disabled so re-enabling
  // resumes wherever the scan has got to.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
      r_digit    <= '1;
      r_font     <= FONT_BLANK;
    end else begin
      if (r_scan_cnt == CNT_LAST) begin
        r_scan_cnt <= '0;
        r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
      r_digit <= bus.i_en ? ~(DIGITS'(1) << r_idx) : '1;
      r_font  <= bus.i_en ? w_font : FONT_BLANK;
    end
  end

  assign bus.o_sum_bcd = r_sum;
  assign bus.o_err     = r_err;
  assign bus.o_busy    = r_busy;
  assign bus.o_digit   = r_digit;
  assign bus.o_fndfont = r_font;

endmodule
`default_nettype wire
